// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding and imem depth helper.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } fseq_state_e;

    function automatic int unsigned fseq_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/fseq_checksum.sv
// Load checksum: running mod-2**DW sum of accepted loader words and compare against exp_sum.
module fseq_checksum #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          add_en,
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] exp_sum,
    output logic          match
);

    logic [DW-1:0] sum_r;

    // Accumulate each accepted word; restart on an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_r <= {DW{1'b0}};
        end else if (clear) begin
            sum_r <= {DW{1'b0}};
        end else if (add_en) begin
            sum_r <= sum_r + data;
        end else begin
            sum_r <= sum_r;
        end
    end

    // Includes the word accepted this cycle so the verdict is ready on the last handshake.
    assign match = ((sum_r + data) == exp_sum);

endmodule

// File: rtl/fetch_sequencer.sv
// Boot-and-fetch controller: loads a program into imem, then sequences fetch at pc_in.
// Optional load checksum (exp_sum / sum_err ports) enabled by defining LOAD_CHECKSUM_EN.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   prog_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_wdata,
    input  logic [DW-1:0] imem_rdata,
    input  logic [31:0]   pc_in,
    output logic          pc_run,
    input  logic          stall_req,
    input  logic          halt_in,
    output logic [DW-1:0] instr_out,
    output logic          instr_valid,
    output logic [1:0]    state_o,
    output logic          err
`ifdef LOAD_CHECKSUM_EN
    ,
    input  logic [DW-1:0] exp_sum,
    output logic          sum_err
`endif
);

    localparam logic [31:0] DEPTH_W   = 32'(fseq_depth(AW));
    localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};

    fseq_state_e   state_r, state_s;
    logic [AW:0]   load_cnt_r, len_r;
    logic          err_r, instr_valid_r, issued_r;
    logic [DW-1:0] instr_hold_r;

    logic          start_ok_s, ld_fire_s, last_word_s, oor_s, issue_s, exit_ok_s;
    logic          ld_ready_s, imem_we_s, pc_run_s;
    logic [AW-1:0] imem_addr_s;
    logic [DW-1:0] imem_wdata_s;

    assign start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_HALT));
    assign ld_fire_s   = (state_r == ST_LOAD) && ld_valid;
    assign last_word_s = ld_fire_s && ((load_cnt_r + CNT_ONE) == len_r);
    assign oor_s       = (pc_in >= DEPTH_W);

`ifdef LOAD_CHECKSUM_EN
    logic sum_match_s;
    logic sum_err_r;

    fseq_checksum #(.DW(DW)) u_checksum (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_ok_s),
        .add_en  (ld_fire_s),
        .data    (ld_data),
        .exp_sum (exp_sum),
        .match   (sum_match_s)
    );

    assign exit_ok_s = sum_match_s;

    // Sticky checksum failure flag, cleared by reset or an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_err_r <= 1'b0;
        end else if (start_ok_s) begin
            sum_err_r <= 1'b0;
        end else if (last_word_s && !sum_match_s) begin
            sum_err_r <= 1'b1;
        end else begin
            sum_err_r <= sum_err_r;
        end
    end

    assign sum_err = sum_err_r;
`else
    assign exit_ok_s = 1'b1;
`endif

    // Next-state and per-state imem / handshake controls.
    always_comb begin
        state_s      = state_r;
        ld_ready_s   = 1'b0;
        imem_we_s    = 1'b0;
        imem_addr_s  = {AW{1'b0}};
        imem_wdata_s = {DW{1'b0}};
        pc_run_s     = 1'b0;
        issue_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_s = (prog_len == 32'd0) ? ST_RUN : ST_LOAD;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                ld_ready_s = 1'b1;
                if (ld_valid) begin
                    imem_we_s    = 1'b1;
                    imem_addr_s  = load_cnt_r[AW-1:0];
                    imem_wdata_s = ld_data;
                end else begin
                    imem_we_s    = 1'b0;
                end
                if (last_word_s) begin
                    state_s = exit_ok_s ? ST_RUN : ST_HALT;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                imem_addr_s = pc_in[AW-1:0];
                pc_run_s    = !stall_req && !oor_s;
                issue_s     = pc_run_s && !halt_in;
                if (halt_in || oor_s) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, load counter, clamped length and sticky range error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            load_cnt_r <= {(AW+1){1'b0}};
            len_r      <= {(AW+1){1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start_ok_s) begin
                load_cnt_r <= {(AW+1){1'b0}};
                len_r      <= (prog_len > DEPTH_W) ? DEPTH_CNT : prog_len[AW:0];
                err_r      <= (prog_len > DEPTH_W);
            end else begin
                if (ld_fire_s) begin
                    load_cnt_r <= load_cnt_r + CNT_ONE;
                end
                if ((state_r == ST_RUN) && oor_s) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    // Fetch pipeline: valid follows an unstalled issue by one cycle and freezes during stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_r      <= 1'b0;
            instr_valid_r <= 1'b0;
            instr_hold_r  <= {DW{1'b0}};
        end else begin
            issued_r <= issue_s;
            if (issued_r) begin
                instr_hold_r <= imem_rdata;
            end
            if ((state_r == ST_RUN) && !halt_in && !oor_s) begin
                if (!stall_req) begin
                    instr_valid_r <= 1'b1;
                end
            end else begin
                instr_valid_r <= 1'b0;
            end
        end
    end

    // Read data arrives the cycle after issue; afterwards the captured copy is shown.
    assign instr_out   = issued_r ? imem_rdata : instr_hold_r;
    assign instr_valid = instr_valid_r;
    assign ld_ready    = ld_ready_s;
    assign imem_we     = imem_we_s;
    assign imem_addr   = imem_addr_s;
    assign imem_wdata  = imem_wdata_s;
    assign pc_run      = pc_run_s;
    assign state_o     = state_r;
    assign err         = err_r;

endmodule
